regfile_mp: RTL

Parametrised multi-port register file for the pipelined MIPS-style core: the next generation of the single-bank register file. It provides NRD combinational read ports with same-cycle write-through bypass and two write ports: a primary writeback port and a secondary port for the multiply high word. It also maintains a hardwired zero register and a compare-flag register updated from writeback data. A per-register pending-write scoreboard lets the decode stage detect RAW hazards without external bookkeeping.

---
 rtl/regfile_mp.sv | 111 +++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-through bypass, a hardwired
// zero register, a compare-flag register and a per-register pending-write
// scoreboard for RAW hazard detection in decode.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   rd_addr    NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data    NRD packed read words, combinational with same-cycle bypass
//   rd_busy    per read port: addressed register still has a pending producer
//   wr_*       primary (writeback) write port
//   wr2_*      secondary (multiply high word) write port, wins address ties
//   cmp_en     update flags {negative, zero} in FLAG_REG[1:0] from wr_data
//   iss_en     mark iss_addr as pending (instruction issued)
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int NRD      = 2,
  parameter int FLAG_REG = 9,
  parameter int HI_REG   = 12,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 wr2_en,
  input  logic [AW-1:0]        wr2_addr,
  input  logic [WIDTH-1:0]     wr2_data,
  input  logic                 cmp_en,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr
);

  localparam logic [AW-1:0] FLAG_A = AW'(FLAG_REG);
  // HI_REG only names the usual multiply-high destination; wr2_addr may
  // target any register, so the value carries no logic of its own.
  localparam logic [AW-1:0] HI_A = AW'(HI_REG);

  logic unused_hi;
  assign unused_hi = ^HI_A;

  logic [DEPTH-1:0][WIDTH-1:0] mem, mem_nxt;
  logic [DEPTH-1:0]            busy, busy_nxt;
  logic [1:0]                  flag_new;

  // {negative, zero}: at most one of the two can be set for any word.
  assign flag_new = {wr_data[WIDTH-1], (wr_data == '0)};

  // Next storage state. Order of the assignments encodes priority:
  // wr2 overrides wr on a tie, the flag update overrides bits [1:0].
  always_comb begin
    mem_nxt = mem;
    if (wr_en)  mem_nxt[wr_addr]  = wr_data;
    if (wr2_en) mem_nxt[wr2_addr] = wr2_data;
    if (cmp_en) mem_nxt[FLAG_A][1:0] = flag_new;
    mem_nxt[0] = '0;
  end

  // Writes retire a producer; an issue in the same cycle is a newer producer
  // and therefore applied last.
  always_comb begin
    busy_nxt = busy;
    if (wr_en)  busy_nxt[wr_addr]  = 1'b0;
    if (wr2_en) busy_nxt[wr2_addr] = 1'b0;
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem  <= '0;
      busy <= '0;
    end else begin
      mem  <= mem_nxt;
      busy <= busy_nxt;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    logic             wr_hit;
    logic             iss_hit;

    assign a = rd_addr[k*AW +: AW];

    // Bypass is suppressed during reset since the writes will be dropped.
    always_comb begin
      d = mem[a];
      if (!rst) begin
        if (wr2_en && (wr2_addr == a))    d = wr2_data;
        else if (wr_en && (wr_addr == a)) d = wr_data;
        if (cmp_en && (a == FLAG_A))      d[1:0] = flag_new;
      end
      if (a == '0) d = '0;
    end

    assign rd_data[k*WIDTH +: WIDTH] = d;

    // A register written this cycle already has its value on the bypass, so
    // it is reported free unless a new producer is issued to it now.
    assign wr_hit  = !rst && ((wr_en && (wr_addr == a)) || (wr2_en && (wr2_addr == a)));
    assign iss_hit = !rst && iss_en && (iss_addr == a);
    assign rd_busy[k] = busy[a] & ~(wr_hit & ~iss_hit);
  end

endmodule
